// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin two-port arbiter/sequencer for a single-port data
//            memory, with access checking and saturating grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [31:0]      p0_addr,
    input  logic [31:0]      p0_wdata,
    output logic             p0_ack,
    output logic             p0_err,
    output logic [31:0]      p0_rdata,
    output logic             p0_stall,
    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [31:0]      p1_addr,
    input  logic [31:0]      p1_wdata,
    output logic             p1_ack,
    output logic             p1_err,
    output logic [31:0]      p1_rdata,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_write_data,
    output logic             mem_read,
    output logic             mem_write,
    input  logic [31:0]      mem_read_data,
    output logic [CNT_W-1:0] p0_grants,
    output logic [CNT_W-1:0] p1_grants
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [29:0]      c_depth = 30'(DEPTH);
    localparam logic [CNT_W-1:0] c_one   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic               r_last_grant;
    logic               r_id;
    logic               r_we;
    logic               r_bad;
    logic               r_rd;
    logic               r_wr;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_p0_ack, r_p1_ack;
    logic               r_p0_err, r_p1_err;
    logic [31:0]        r_p0_rdata, r_p1_rdata;
    logic [CNT_W-1:0]   r_p0_grants, r_p1_grants;

    logic               w_pick1;
    logic               w_sel_we;
    logic [31:0]        w_sel_addr;
    logic [31:0]        w_sel_wdata;
    logic               w_sel_bad;
    logic               w_is_read;

    // On a tie the port that did not win last time gets the slot.
    assign w_pick1     = p1_req & (~p0_req | ~r_last_grant);
    assign w_sel_we    = w_pick1 ? p1_we    : p0_we;
    assign w_sel_addr  = w_pick1 ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_pick1 ? p1_wdata : p0_wdata;
    assign w_sel_bad   = (w_sel_addr[1:0] != 2'b00) | (w_sel_addr[31:2] >= c_depth);
    assign w_is_read   = ~r_bad & ~r_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_we         <= 1'b0;
            r_bad        <= 1'b0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p0_err     <= 1'b0;
            r_p1_err     <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
            r_p0_grants  <= '0;
            r_p1_grants  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (p0_req | p1_req) begin
                        r_id         <= w_pick1;
                        r_we         <= w_sel_we;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_bad        <= w_sel_bad;
                        r_rd         <= ~w_sel_bad & ~w_sel_we;
                        r_wr         <= ~w_sel_bad & w_sel_we;
                        r_last_grant <= w_pick1;
                        if (w_pick1) begin
                            if (r_p1_grants != '1)
                                r_p1_grants <= r_p1_grants + c_one;
                        end else begin
                            if (r_p0_grants != '1)
                                r_p0_grants <= r_p0_grants + c_one;
                        end
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_rd       <= 1'b0;
                    r_wr       <= 1'b0;
                    r_p0_ack   <= ~r_id;
                    r_p1_ack   <= r_id;
                    r_p0_err   <= ~r_id & r_bad;
                    r_p1_err   <= r_id & r_bad;
                    r_p0_rdata <= (~r_id & w_is_read) ? mem_read_data : 32'h0;
                    r_p1_rdata <= (r_id & w_is_read)  ? mem_read_data : 32'h0;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    r_p0_ack   <= 1'b0;
                    r_p1_ack   <= 1'b0;
                    r_p0_err   <= 1'b0;
                    r_p1_err   <= 1'b0;
                    r_p0_rdata <= '0;
                    r_p1_rdata <= '0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobes drop combinationally with reset so an interrupted write never lands.
    assign mem_read       = r_rd & ~reset;
    assign mem_write      = r_wr & ~reset;
    assign mem_address    = r_addr;
    assign mem_write_data = r_wdata;

    assign p0_ack    = r_p0_ack;
    assign p1_ack    = r_p1_ack;
    assign p0_err    = r_p0_err;
    assign p1_err    = r_p1_err;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;
    assign p0_stall  = p0_req & ~r_p0_ack;
    assign p0_grants = r_p0_grants;
    assign p1_grants = r_p1_grants;

endmodule
`default_nettype wire
